cpu_datapath: RTL and testbench
===============================

// Module: cpu_datapath
// PURPOSE
//  32-bit single-bus datapath of the Mini-SRC CPU. Bus sources: 16 GPRs, PC, MDR, Y, Z(64), HI, LO, InPort, IR constant.
//  Sinks: PC, IR, MAR, MDR, Y, Z, HI, LO, GPRs, OutPort, CON flip-flop.
//  The external control unit, or a bench, drives one-hot micro-op strobes each cycle.
// PARAMETERS
//  (none; fixed 32-bit datapath and 16 registers)
// PORTS
//  Clock          in   1   single clock; all state updates on its rising edge
//  Clear          in   1   reset, asynchronous, active-high; zeroes every register
//  OutPort_output out  32  OutPort register contents
//  IncPC          in   1   ALU output forced to bus+1
//  CONin          in   1   load CON flip-flop from the branch condition
//  RAM_write      in   1   write MDR to RAM[MAR] (CPU_DP_RAM_EN only)
//  MDR_enable     in   1   load MDR
//  MDRout         in   1   MDR drives bus
//  MAR_enable     in   1   load MAR from bus
//  IR_enable      in   1   load IR from bus
//  MDR_read       in   1   MDR input mux: 1 = memory data, 0 = bus
//  Gra/Grb/Grc    in   1   select Ra=IR[26:23] / Rb=IR[22:19] / Rc=IR[18:15]
//  HI_enable, LO_enable, Y_enable, PC_enable, OutPort_enable   in 1   load from bus
//  ZHighIn/ZLowIn in   1   load Z[63:32] / Z[31:0] from ALU result
//  InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, MDRout   in 1   drive bus
//  BAout          in   1   selected GPR drives bus; R0 reads as 0
//  Cout           in   1   drives sign-extended IR[18:0] onto bus
//  InPort_input   in   32  external input port value
//  Mdatain        in   32  memory read data
//  R_in / R_out   in   1   write bus to / drive bus from the selected GPR
//  Cin            in   1   ALU carry-in for add/sub
//  branch_flag    in   1   1 = PC load is conditional on CON
// BEHAVIOUR
//  Reset: all registers, CON and OutPort_output clear to 0 immediately on Clear=1, independent of Clock.
//  Bus: combinational mux; at most one source is active per cycle.
//   Priority if several: MDR>PC>Zlo>Zhi>HI>LO>Y>InPort>C>GPR. No source active -> bus = 0.
//  GPR select: reg index = OR of the enabled Gra/Grb/Grc fields.
//   R_in writes bus to that register next edge; writes to R0 are ignored under BAout semantics only (R0 is writable via R_in).
//   R_out drives the real register; BAout drives 0 when the index is 0.
//  ALU (combinational): A=Y, B=bus. Op = IR[31:27].
//   add/addi/ld/ldi/st/br/jr/jal/others: A+B+Cin
//   sub 00100: A-B-Cin; and 01001/andi 01100: A&B; or 01010/ori 01101: A|B
//   shr 00101: A>>B[4:0] (logical); shl 00110: A<<B[4:0]; ror 00111 / rol 01000: rotate by B[4:0]
//   mul 01110: signed 64-bit A*B; div 01111: Zlo=A/B, Zhi=A%B (signed); B=0 -> Z=0
//   neg 10000: -B; not 10001: ~B
//   Non-mul/div results: Z[63:32] = 0.
//  IncPC=1 overrides the opcode: result = bus+1, high = 0.
//  MDR: on MDR_enable, loads Mdatain when MDR_read=1, else loads the bus.
//  CON: on CONin, C2 = IR[20:19] tested against the bus: 00 ==0; 01 !=0; 10 >=0 (signed); 11 <0.
//  PC: loads the bus when PC_enable && (!branch_flag || CON). PC wraps modulo 2^32.
//  OutPort: loads the bus on OutPort_enable. InPortout drives InPort_input directly (no register).
//  Every enable takes effect at the next rising edge: a one-cycle latency from strobe to register.
//  Simultaneous load and drive of the same register: the bus carries the old value, and the register captures that same value.
// CONFIGURATION
//  CPU_DP_RAM_EN defined: internal 512x32 synchronous RAM addressed by MAR[8:0].
//   RAM_write writes MDR on the edge. With MDR_read, MDR loads RAM[MAR], and Mdatain is ignored. RAM is not cleared by Clear.
//  CPU_DP_RAM_EN undefined: no RAM, RAM_write is ignored, and MDR memory data comes from Mdatain.
// TESTING
//  Clear=1 mid-run -> PC, IR, MAR, MDR, Y, Z, HI, LO, GPRs, OutPort_output all 0 without a clock edge.
//  Fetch, PC=0: T0 PCout,MAR_enable,IncPC,ZLowIn -> T1 Mdatain=0x00900002, MDR_read,MDR_enable,ZLowout,PC_enable -> T2 MDRout,IR_enable.
//   Result: MAR=0, PC=1, IR=0x00900002.
//  ld R1,2(R2) with R2=0x10, Mdatain=0x1234: T3 Grb,BAout,Y_enable; T4 Cout,ZLowIn -> Zlo=0x12; T5 ZLowout,MAR_enable -> MAR=0x12.
//   Then T6 MDR_read,MDR_enable; T7 Gra,R_in,MDRout -> R1=0x1234.
//  BAout with Rb=R0 holding 5: Y <- 0; same case with R_out: Y <- 5.
//  mul IR opcode 01110, Y=-3, bus=7; ZHighIn+ZLowIn -> Z=0xFFFFFFFF_FFFFFFEB. div 17/5 -> Zlo=3, Zhi=2.
//  brzr IR[20:19]=00, bus=0, CONin -> CON=1. With branch_flag=1, PC_enable loads the bus value.
//   With bus=4 (CON=0), PC is unchanged.

Source files
------------

// File: rtl/cpu_datapath.sv
// Mini-SRC single-bus 32-bit datapath: register file, bus mux, ALU, CON logic and I/O ports.
// Define CPU_DP_RAM_EN to add an internal 512x32 RAM behind MAR/MDR.
module cpu_datapath (
    input  logic        Clock,
    input  logic        Clear,
    output logic [31:0] OutPort_output,
    input  logic        IncPC,
    input  logic        CONin,
    input  logic        RAM_write,
    input  logic        MDR_enable,
    input  logic        MDRout,
    input  logic        MAR_enable,
    input  logic        IR_enable,
    input  logic        MDR_read,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        HI_enable,
    input  logic        LO_enable,
    input  logic        Y_enable,
    input  logic        PC_enable,
    input  logic        OutPort_enable,
    input  logic        ZHighIn,
    input  logic        ZLowIn,
    input  logic        InPortout,
    input  logic        PCout,
    input  logic        Yout,
    input  logic        ZLowout,
    input  logic        ZHighout,
    input  logic        LOout,
    input  logic        HIout,
    input  logic        BAout,
    input  logic        Cout,
    input  logic [31:0] InPort_input,
    input  logic [31:0] Mdatain,
    input  logic        R_in,
    input  logic        R_out,
    input  logic        Cin,
    input  logic        branch_flag
);

    logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q, zlo_q, zhi_q, hi_q, lo_q, out_q;
    logic        con_q;
    logic [31:0] gpr_q [16];

    logic [3:0]  sel;
    logic [31:0] c_sext, gpr_rd, bus, mem_data;
    logic [63:0] alu_res, rot;
    logic [4:0]  sh;
    logic        cond;

    assign sel    = ({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19]) | ({4{Grc}} & ir_q[18:15]);
    assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};
    // BAout treats R0 as a hard zero (base-address semantics); R_out sees the real register.
    assign gpr_rd = (!R_out && sel == 4'd0) ? 32'd0 : gpr_q[sel];

    always_comb begin
        bus = 32'd0;
        if (MDRout)                bus = mdr_q;
        else if (PCout)            bus = pc_q;
        else if (ZLowout)          bus = zlo_q;
        else if (ZHighout)         bus = zhi_q;
        else if (HIout)            bus = hi_q;
        else if (LOout)            bus = lo_q;
        else if (Yout)             bus = y_q;
        else if (InPortout)        bus = InPort_input;
        else if (Cout)             bus = c_sext;
        else if (R_out || BAout)   bus = gpr_rd;
    end

    assign sh = bus[4:0];

    always_comb begin
        alu_res = 64'd0;
        rot     = 64'd0;
        if (IncPC) begin
            alu_res[31:0] = bus + 32'd1;
        end else begin
            case (ir_q[31:27])
                5'b00100: alu_res[31:0] = y_q - bus - {31'd0, Cin};
                5'b01001, 5'b01100: alu_res[31:0] = y_q & bus;
                5'b01010, 5'b01101: alu_res[31:0] = y_q | bus;
                5'b00101: alu_res[31:0] = y_q >> sh;
                5'b00110: alu_res[31:0] = y_q << sh;
                5'b00111: begin
                    rot           = {y_q, y_q} >> sh;
                    alu_res[31:0] = rot[31:0];
                end
                5'b01000: begin
                    rot           = {y_q, y_q} << sh;
                    alu_res[31:0] = rot[63:32];
                end
                5'b01110: alu_res = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
                5'b01111: begin
                    if (bus != 32'd0) begin
                        alu_res[31:0]  = $signed(y_q) / $signed(bus);
                        alu_res[63:32] = $signed(y_q) % $signed(bus);
                    end
                end
                5'b10000: alu_res[31:0] = 32'd0 - bus;
                5'b10001: alu_res[31:0] = ~bus;
                default:  alu_res[31:0] = y_q + bus + {31'd0, Cin};
            endcase
        end
    end

    always_comb begin
        case (ir_q[20:19])
            2'b00:   cond = (bus == 32'd0);
            2'b01:   cond = (bus != 32'd0);
            2'b10:   cond = !bus[31];
            default: cond = bus[31];
        endcase
    end

`ifdef CPU_DP_RAM_EN
    logic [31:0] ram [512];
    logic        unused_ram_cfg;

    // Not cleared by Clear: memory contents survive a CPU reset.
    always_ff @(posedge Clock) begin
        if (RAM_write) ram[mar_q[8:0]] <= mdr_q;
    end

    assign mem_data       = ram[mar_q[8:0]];
    assign unused_ram_cfg = ^{mar_q[31:9], Mdatain};
`else
    logic unused_ram_cfg;

    assign mem_data       = Mdatain;
    assign unused_ram_cfg = ^{RAM_write, mar_q};
`endif

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            zlo_q <= '0;
            zhi_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            out_q <= '0;
            con_q <= 1'b0;
            for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
        end else begin
            if (PC_enable && (!branch_flag || con_q)) pc_q <= bus;
            if (IR_enable)      ir_q  <= bus;
            if (MAR_enable)     mar_q <= bus;
            if (MDR_enable)     mdr_q <= MDR_read ? mem_data : bus;
            if (Y_enable)       y_q   <= bus;
            if (ZLowIn)         zlo_q <= alu_res[31:0];
            if (ZHighIn)        zhi_q <= alu_res[63:32];
            if (HI_enable)      hi_q  <= bus;
            if (LO_enable)      lo_q  <= bus;
            if (OutPort_enable) out_q <= bus;
            if (CONin)          con_q <= cond;
            if (R_in)           gpr_q[sel] <= bus;
        end
    end

    assign OutPort_output = out_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus randomized ALU, CON/branch and
// register-file traffic compared against a behavioural model; registers observed through OutPort.
module tb_cpu_datapath;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] OutPort_output;
    logic        IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read;
    logic        Gra, Grb, Grc, HI_enable, LO_enable, Y_enable, PC_enable, OutPort_enable;
    logic        ZHighIn, ZLowIn, InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout;
    logic        BAout, Cout, R_in, R_out, Cin, branch_flag;
    logic [31:0] InPort_input, Mdatain;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    cpu_datapath dut (
        .Clock(Clock), .Clear(Clear), .OutPort_output(OutPort_output), .IncPC(IncPC),
        .CONin(CONin), .RAM_write(RAM_write), .MDR_enable(MDR_enable), .MDRout(MDRout),
        .MAR_enable(MAR_enable), .IR_enable(IR_enable), .MDR_read(MDR_read), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .HI_enable(HI_enable), .LO_enable(LO_enable),
        .Y_enable(Y_enable), .PC_enable(PC_enable), .OutPort_enable(OutPort_enable),
        .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .InPortout(InPortout), .PCout(PCout),
        .Yout(Yout), .ZLowout(ZLowout), .ZHighout(ZHighout), .LOout(LOout), .HIout(HIout),
        .BAout(BAout), .Cout(Cout), .InPort_input(InPort_input), .Mdatain(Mdatain),
        .R_in(R_in), .R_out(R_out), .Cin(Cin), .branch_flag(branch_flag)
    );

    task automatic idle();
        {IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read} = '0;
        {Gra, Grb, Grc, HI_enable, LO_enable, Y_enable, PC_enable, OutPort_enable} = '0;
        {ZHighIn, ZLowIn, InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout} = '0;
        {BAout, Cout, R_in, R_out, Cin, branch_flag} = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    // Caller raises a bus source first; the value lands in OutPort one edge later.
    task automatic peek(output logic [31:0] v);
        OutPort_enable = 1'b1;
        tick();
        v = OutPort_output;
    endtask

    task automatic load_ir(input logic [31:0] v);
        InPort_input = v; InPortout = 1'b1; IR_enable = 1'b1;
        tick();
    endtask

    task automatic load_y(input logic [31:0] v);
        InPort_input = v; InPortout = 1'b1; Y_enable = 1'b1;
        tick();
    endtask

    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin,
                                            input logic inc);
        longint      sa, sb, p;
        logic [31:0] r;
        logic [63:0] res;
        sa = $signed(a);
        sb = $signed(b);
        if (inc) return {32'd0, b + 32'd1};
        case (op)
            5'd4:         res = {32'd0, a - b - 32'(cin)};
            5'd9, 5'd12:  res = {32'd0, a & b};
            5'd10, 5'd13: res = {32'd0, a | b};
            5'd5:         res = {32'd0, a >> b[4:0]};
            5'd6:         res = {32'd0, a << b[4:0]};
            5'd7: begin
                r = a;
                for (int i = 0; i < int'(b[4:0]); i++) r = {r[0], r[31:1]};
                res = {32'd0, r};
            end
            5'd8: begin
                r = a;
                for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], r[31]};
                res = {32'd0, r};
            end
            5'd14: begin
                p   = sa * sb;
                res = p;
            end
            5'd15: begin
                if (b == 32'd0) res = 64'd0;
                else begin
                    p   = sa / sb;
                    res[31:0] = p[31:0];
                    p   = sa % sb;
                    res[63:32] = p[31:0];
                end
            end
            5'd16:   res = {32'd0, -b};
            5'd17:   res = {32'd0, ~b};
            default: res = {32'd0, a + b + 32'(cin)};
        endcase
        return res;
    endfunction

    function automatic logic ref_cond(input logic [1:0] c2, input logic [31:0] v);
        int sv;
        sv = $signed(v);
        case (c2)
            2'd0:    return v == 0;
            2'd1:    return v != 0;
            2'd2:    return sv >= 0;
            default: return sv < 0;
        endcase
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        checks++;
        if (OutPort_output !== 32'd0) begin
            errors++; $display("FAIL reset_out: got %h want %h", OutPort_output, 32'd0);
        end
        InPort_input = 32'hCAFE; InPortout = 1'b1; OutPort_enable = 1'b1;
        PC_enable = 1'b1; Y_enable = 1'b1;
        tick();
        checks++;
        if (OutPort_output !== 32'hCAFE) begin
            errors++; $display("FAIL out_load: got %h want %h", OutPort_output, 32'hCAFE);
        end
        Clear = 1'b1;
        #1;
        checks++;
        if (OutPort_output !== 32'd0) begin
            errors++; $display("FAIL async_clear: got %h want %h", OutPort_output, 32'd0);
        end
        Clear = 1'b0;
        #1;
        PCout = 1'b1; peek(v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL clear_pc: got %h want %h", v, 32'd0); end
        Yout = 1'b1; peek(v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL clear_y: got %h want %h", v, 32'd0); end
    endtask

    task automatic test_fetch();
        logic [31:0] v;
        PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
        tick();
        Mdatain = 32'h0090_0002; MDR_read = 1'b1; MDR_enable = 1'b1; ZLowout = 1'b1;
        PC_enable = 1'b1;
        tick();
        MDRout = 1'b1; IR_enable = 1'b1;
        tick();
        PCout = 1'b1; peek(v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL fetch_pc: got %h want %h", v, 32'd1); end
        Cout = 1'b1; peek(v);
        checks++;
        if (v !== 32'd2) begin errors++; $display("FAIL fetch_ir_c: got %h want %h", v, 32'd2); end
    endtask

    task automatic test_ld();
        logic [31:0] v;
        InPort_input = 32'h10; InPortout = 1'b1; Grb = 1'b1; R_in = 1'b1;
        tick();
        Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
        tick();
        Cout = 1'b1; ZLowIn = 1'b1;
        tick();
        ZLowout = 1'b1; MAR_enable = 1'b1;
        tick();
        Mdatain = 32'h1234; MDR_read = 1'b1; MDR_enable = 1'b1;
        tick();
        Gra = 1'b1; R_in = 1'b1; MDRout = 1'b1;
        tick();
        ZLowout = 1'b1; peek(v);
        checks++;
        if (v !== 32'h12) begin errors++; $display("FAIL ld_zlo: got %h want %h", v, 32'h12); end
        Gra = 1'b1; R_out = 1'b1; peek(v);
        checks++;
        if (v !== 32'h1234) begin errors++; $display("FAIL ld_r1: got %h want %h", v, 32'h1234); end
    endtask

    task automatic test_ba_r0();
        logic [31:0] v;
        load_ir(32'd0);
        InPort_input = 32'd5; InPortout = 1'b1; Grb = 1'b1; R_in = 1'b1;
        tick();
        Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
        tick();
        Yout = 1'b1; peek(v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL baout_r0: got %h want %h", v, 32'd0); end
        Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1;
        tick();
        Yout = 1'b1; peek(v);
        checks++;
        if (v !== 32'd5) begin errors++; $display("FAIL rout_r0: got %h want %h", v, 32'd5); end
    endtask

    task automatic test_mul_div();
        logic [31:0] hi, lo;
        logic [31:0] ops [3]   = '{32'h7000_0000, 32'h7800_0000, 32'h7800_0000};
        logic [31:0] as [3]    = '{32'hFFFF_FFFD, 32'd17, 32'd17};
        logic [31:0] bs [3]    = '{32'd7, 32'd5, 32'd0};
        logic [63:0] want [3]  = '{64'hFFFF_FFFF_FFFF_FFEB, {32'd2, 32'd3}, 64'd0};
        for (int i = 0; i < 3; i++) begin
            load_ir(ops[i]);
            load_y(as[i]);
            InPort_input = bs[i]; InPortout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1;
            tick();
            ZHighout = 1'b1; peek(hi);
            ZLowout = 1'b1; peek(lo);
            checks++;
            if ({hi, lo} !== want[i]) begin
                errors++; $display("FAIL muldiv_%0d: got %h want %h", i, {hi, lo}, want[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] v;
        load_ir(32'd0);
        InPort_input = 32'd0; InPortout = 1'b1; CONin = 1'b1;
        tick();
        InPort_input = 32'h40; InPortout = 1'b1; PC_enable = 1'b1; branch_flag = 1'b1;
        tick();
        PCout = 1'b1; peek(v);
        checks++;
        if (v !== 32'h40) begin errors++; $display("FAIL brzr_taken: got %h want %h", v, 32'h40); end
        InPort_input = 32'd4; InPortout = 1'b1; CONin = 1'b1;
        tick();
        InPort_input = 32'h99; InPortout = 1'b1; PC_enable = 1'b1; branch_flag = 1'b1;
        tick();
        PCout = 1'b1; peek(v);
        checks++;
        if (v !== 32'h40) begin errors++; $display("FAIL brzr_not: got %h want %h", v, 32'h40); end
    endtask

    task automatic test_bus_rules();
        logic [31:0] v;
        Mdatain = 32'hA5A5; MDR_read = 1'b1; MDR_enable = 1'b1;
        tick();
        MDRout = 1'b1; PCout = 1'b1; InPortout = 1'b1; InPort_input = 32'h55; peek(v);
        checks++;
        if (v !== 32'hA5A5) begin errors++; $display("FAIL prio_mdr: got %h want %h", v, 32'hA5A5); end
        PCout = 1'b1; InPortout = 1'b1; Cout = 1'b1; peek(v);
        checks++;
        if (v !== 32'h40) begin errors++; $display("FAIL prio_pc: got %h want %h", v, 32'h40); end
        peek(v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL bus_idle: got %h want %h", v, 32'd0); end
        load_y(32'h77);
        Yout = 1'b1; Y_enable = 1'b1; peek(v);
        checks++;
        if (v !== 32'h77) begin errors++; $display("FAIL self_load: got %h want %h", v, 32'h77); end
        Yout = 1'b1; peek(v);
        checks++;
        if (v !== 32'h77) begin errors++; $display("FAIL self_keep: got %h want %h", v, 32'h77); end
        load_ir((32'd1 << 23) | (32'd2 << 19) | (32'd3 << 15));
        InPort_input = 32'hBEEF; InPortout = 1'b1; Gra = 1'b1; Grb = 1'b1; R_in = 1'b1;
        tick();
        Grc = 1'b1; R_out = 1'b1; peek(v);
        checks++;
        if (v !== 32'hBEEF) begin errors++; $display("FAIL sel_or: got %h want %h", v, 32'hBEEF); end
        InPort_input = 32'h1357; InPortout = 1'b1; HI_enable = 1'b1;
        tick();
        InPort_input = 32'h2468; InPortout = 1'b1; LO_enable = 1'b1;
        tick();
        HIout = 1'b1; LOout = 1'b1; peek(v);
        checks++;
        if (v !== 32'h1357) begin errors++; $display("FAIL prio_hi: got %h want %h", v, 32'h1357); end
        LOout = 1'b1; peek(v);
        checks++;
        if (v !== 32'h2468) begin errors++; $display("FAIL lo_read: got %h want %h", v, 32'h2468); end
    endtask

    task automatic test_random_alu();
        logic [4:0]  op_list [15] = '{0, 4, 5, 6, 7, 8, 9, 10, 12, 13, 14, 15, 16, 17, 3};
        logic [4:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        cin, inc;
        logic [63:0] want;
        for (int i = 0; i < 45; i++) begin
            op  = (i < 30) ? op_list[i % 15] : 5'($urandom);
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 3) == 0) b = -b;
            if (op == 5'd15 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            cin = 1'($urandom);
            inc = ($urandom_range(0, 6) == 0);
            load_ir({op, 27'($urandom)});
            load_y(a);
            InPort_input = b; InPortout = 1'b1; Cin = cin; IncPC = inc;
            ZHighIn = 1'b1; ZLowIn = 1'b1;
            tick();
            want = ref_alu(op, a, b, cin, inc);
            ZHighout = 1'b1; peek(hi);
            ZLowout = 1'b1; peek(lo);
            checks++;
            if ({hi, lo} !== want) begin
                errors++;
                $display("FAIL alu op=%0d a=%h b=%h cin=%0d inc=%0d: got %h want %h",
                         op, a, b, cin, inc, {hi, lo}, want);
            end
        end
    endtask

    task automatic test_random_branch();
        logic [31:0] exp_pc, v, t, npc;
        logic [1:0]  c2;
        logic        exp_con;
        exp_pc = $urandom;
        InPort_input = exp_pc; InPortout = 1'b1; PC_enable = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            c2 = 2'(i);
            case ($urandom_range(0, 3))
                0:       t = 32'd0;
                1:       t = 32'($urandom_range(1, 100));
                2:       t = 32'h8000_0000 | $urandom;
                default: t = $urandom;
            endcase
            v = $urandom;
            load_ir((v & ~(32'd3 << 19)) | (32'(c2) << 19));
            InPort_input = t; InPortout = 1'b1; CONin = 1'b1;
            tick();
            exp_con = ref_cond(c2, t);
            npc = $urandom;
            InPort_input = npc; InPortout = 1'b1; PC_enable = 1'b1; branch_flag = 1'b1;
            tick();
            if (exp_con) exp_pc = npc;
            PCout = 1'b1; peek(v);
            checks++;
            if (v !== exp_pc) begin
                errors++;
                $display("FAIL branch c2=%0d val=%h: got pc %h want %h", c2, t, v, exp_pc);
            end
        end
    endtask

    task automatic test_random_gpr();
        logic [31:0] regs [16];
        logic [31:0] v, want;
        logic [3:0]  idx;
        for (int i = 0; i < 16; i++) begin
            regs[i] = $urandom;
            load_ir(32'(i) << 15);
            InPort_input = regs[i]; InPortout = 1'b1; Grc = 1'b1; R_in = 1'b1;
            tick();
        end
        for (int i = 0; i < 30; i++) begin
            idx = 4'($urandom);
            load_ir(32'(idx) << 15);
            if ($urandom_range(0, 2) == 0) begin
                regs[idx] = $urandom;
                InPort_input = regs[idx]; InPortout = 1'b1; Grc = 1'b1; R_in = 1'b1;
                tick();
            end
            if ($urandom_range(0, 1) == 0) begin
                Grc = 1'b1; R_out = 1'b1; peek(v);
                want = regs[idx];
            end else begin
                Grc = 1'b1; BAout = 1'b1; peek(v);
                want = (idx == 0) ? 32'd0 : regs[idx];
            end
            checks++;
            if (v !== want) begin
                errors++; $display("FAIL gpr r%0d: got %h want %h", idx, v, want);
            end
        end
    endtask

    initial begin
        idle();
        Clear = 1'b1;
        InPort_input = '0;
        Mdatain = '0;
        #12;
        Clear = 1'b0;
        test_reset();
        test_fetch();
        test_ld();
        test_ba_r0();
        test_mul_div();
        test_branch();
        test_bus_rules();
        test_random_alu();
        test_random_branch();
        test_random_gpr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
